// File: rtl/mem_scan_reader.sv
// mem_scan_reader: sweeps a block-RAM read port over an address window and streams the words out.
// Define SCAN_CHECKSUM_EN to build the XOR checksum of emitted words; otherwise checksum reads 0.
module mem_scan_reader #(
    parameter int WID_MEM   = 1,
    parameter int EXP_MEM   = 16,
    parameter int DEPTH_MEM = 2**16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [EXP_MEM-1:0] base_addr,
    input  logic [EXP_MEM:0]   count,
    output logic               busy,
    output logic               done,
    output logic [EXP_MEM-1:0] raddr,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic               m_valid,
    output logic [WID_MEM-1:0] m_data,
    output logic               m_last,
    input  logic               m_ready,
    output logic [WID_MEM-1:0] checksum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [EXP_MEM-1:0] LAST_ADDR = EXP_MEM'(DEPTH_MEM - 1);
    localparam logic [EXP_MEM:0]   CNT_ONE   = (EXP_MEM+1)'(1);

    // Explicit wrap so non-power-of-two depths return to address 0.
    function automatic logic [EXP_MEM-1:0] wrap_inc(input logic [EXP_MEM-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + EXP_MEM'(1);
    endfunction

    logic [1:0]         state;
    logic [EXP_MEM:0]   rem;
    logic               vld_p0, last_p0;
    logic               vld_p1, last_p1;
    logic [WID_MEM-1:0] fifo_data [0:1];
    logic               fifo_last [0:1];
    logic               rd_ptr, wr_ptr;
    logic [1:0]         occ;

    logic       pop, accept, issue_run, issue, issue_last, capture, adv_p1, credit_ok;
    logic [2:0] load;

    assign m_valid = (occ != 2'd0);
    assign m_data  = fifo_data[rd_ptr];
    assign m_last  = m_valid & fifo_last[rd_ptr];
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_FIN);

    assign pop    = m_valid & m_ready;
    assign accept = (state == S_IDLE) & start;

    // Words in the system: FIFO entries plus reads at the raddr and dout stages.
    // The memory output register acts as a third slot: a word on dout that cannot
    // be captured is held there because raddr does not move while it waits.
    assign load      = {1'b0, occ} + {2'b0, vld_p0} + {2'b0, vld_p1};
    assign credit_ok = ((load - {2'b0, pop}) < 3'd3);

    assign issue_run  = (state == S_RUN) & (rem != '0) & credit_ok;
    assign issue      = (accept & (count != '0)) | issue_run;
    assign issue_last = accept ? (count == CNT_ONE) : (rem == CNT_ONE);

    assign capture = vld_p1 & ((occ != 2'd2) | pop);
    assign adv_p1  = ~vld_p1 | capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rem          <= '0;
            raddr        <= '0;
            vld_p0       <= 1'b0;
            last_p0      <= 1'b0;
            vld_p1       <= 1'b0;
            last_p1      <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            occ          <= 2'd0;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= (count == '0) ? S_FIN : S_RUN;
                S_RUN:   if ((issue_run && rem == CNT_ONE) || rem == '0) state <= S_DRAIN;
                S_DRAIN: if (pop && m_last) state <= S_FIN;
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (accept)
                rem <= (count == '0) ? '0 : count - CNT_ONE;
            else if (issue_run)
                rem <= rem - CNT_ONE;

            // stage p0: address presented to the memory
            if (issue) begin
                raddr   <= accept ? base_addr : wrap_inc(raddr);
                last_p0 <= issue_last;
            end
            vld_p0 <= issue;

            // stage p1: word on mem_dout
            if (adv_p1) begin
                vld_p1  <= vld_p0;
                last_p1 <= last_p0;
            end

            // stage p2: output FIFO
            if (capture) begin
                fifo_data[wr_ptr] <= mem_dout;
                fifo_last[wr_ptr] <= last_p1;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, capture} - {1'b0, pop};
        end
    end

`ifdef SCAN_CHECKSUM_EN
    logic [WID_MEM-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset)
            csum_q <= '0;
        else if (accept)
            csum_q <= '0;
        else if (pop)
            csum_q <= csum_q ^ m_data;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_scan_reader.sv
// Self-checking bench for mem_scan_reader with a small non-power-of-two memory model.
// Expected words and last flags are queued at start and popped as beats handshake.
module tb_mem_scan_reader;

    localparam int WID   = 8;
    localparam int EXP   = 5;
    localparam int DEPTH = 20;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [EXP-1:0] base_addr;
    logic [EXP:0]   count;
    logic           busy, done;
    logic [EXP-1:0] raddr;
    logic [WID-1:0] mem_dout;
    logic           m_valid;
    logic [WID-1:0] m_data;
    logic           m_last;
    logic           m_ready;
    logic [WID-1:0] checksum;

    logic [WID-1:0] mem [0:DEPTH-1];

    logic [WID-1:0] sb_data [$];
    bit             sb_last [$];

    int errors = 0;
    int checks = 0;

    mem_scan_reader #(.WID_MEM(WID), .EXP_MEM(EXP), .DEPTH_MEM(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .raddr(raddr), .mem_dout(mem_dout),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_dout <= mem[raddr];

    task automatic run_scan(input int base, input int cnt, input bit rnd, input bit poke);
        int cyc, beats, first_cyc, last_cyc, done_cyc, budget;
        bit prev_stall;
        logic [WID-1:0] prev_data, exp_w, exp_sum, exp_ra;
        bit exp_l;
        @(negedge clk);
        exp_sum = '0;
        for (int i = 0; i < cnt; i++) begin
            exp_w = mem[(base + i) % DEPTH];
            sb_data.push_back(exp_w);
            sb_last.push_back(i == cnt - 1);
            exp_sum ^= exp_w;
        end
        start = 1'b1; base_addr = EXP'(base); count = (EXP+1)'(cnt); m_ready = 1'b1;
        cyc = 0; beats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        prev_stall = 1'b0; prev_data = '0; budget = 8 * cnt + 20;
        while (done_cyc < 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL busy_after_start: got %b expected 1", busy);
                end
            end
            if (poke && cyc == 2) begin
                start = 1'b1; base_addr = '0; count = (EXP+1)'(5);
            end else if (poke && cyc == 3) begin
                start = 1'b0;
            end
            if (!rnd && cnt != 0 && cyc <= cnt) begin
                exp_ra = WID'((base + cyc - 1) % DEPTH);
                checks++;
                if (raddr !== exp_ra[EXP-1:0]) begin
                    errors++; $display("FAIL raddr_seq[%0d]: got %0d expected %0d", cyc, raddr, exp_ra);
                end
            end
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%0h expected valid=1 data=%0h",
                             m_valid, m_data, prev_data);
                end
            end
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            if (m_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (sb_data.size() == 0) begin
                    errors++; $display("FAIL extra_beat: got data=%0h expected no beat", m_data);
                end else begin
                    exp_w = sb_data.pop_front();
                    exp_l = sb_last.pop_front();
                    if (m_data !== exp_w || m_last !== exp_l) begin
                        errors++;
                        $display("FAIL beat[%0d]: got data=%0h last=%b expected data=%0h last=%b",
                                 beats, m_data, m_last, exp_w, exp_l);
                    end
                    beats++;
                    if (exp_l) last_cyc = cyc;
                end
            end
            prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
            prev_data  = m_data;
            if (done === 1'b1) begin
                done_cyc = cyc;
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL busy_at_done: got %b expected 1", busy);
                end
`ifdef SCAN_CHECKSUM_EN
                checks++;
                if (checksum !== exp_sum) begin
                    errors++; $display("FAIL checksum: got %0h expected %0h", checksum, exp_sum);
                end
`else
                checks++;
                if (checksum !== '0) begin
                    errors++; $display("FAIL checksum_tied: got %0h expected 0", checksum);
                end
`endif
            end
        end
        checks++;
        if (done_cyc < 0) begin
            errors++; $display("FAIL timeout: got no done in %0d cycles expected done", budget);
        end
        checks++;
        if (beats != cnt) begin
            errors++; $display("FAIL beat_count: got %0d expected %0d", beats, cnt);
        end
        checks++;
        if (first_cyc != (cnt == 0 ? -1 : 3)) begin
            errors++; $display("FAIL first_valid_cycle: got %0d expected %0d", first_cyc, (cnt == 0 ? -1 : 3));
        end
        checks++;
        if (done_cyc >= 0 && done_cyc != (cnt == 0 ? 1 : last_cyc + 1)) begin
            errors++; $display("FAIL done_timing: got %0d expected %0d", done_cyc, (cnt == 0 ? 1 : last_cyc + 1));
        end
        if (!rnd && cnt != 0) begin
            checks++;
            if (last_cyc != cnt + 2) begin
                errors++; $display("FAIL consecutive_beats: got last at %0d expected %0d", last_cyc, cnt + 2);
            end
        end
        checks++;
        if (sb_data.size() != 0) begin
            errors++; $display("FAIL scoreboard_left: got %0d words expected 0", sb_data.size());
        end
        sb_data.delete(); sb_last.delete();
        m_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL idle_after_done: got busy=%b done=%b expected 0 0", busy, done);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || raddr !== '0 || m_valid !== 1'b0 ||
            m_last !== 1'b0 || m_data !== '0 || checksum !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b raddr=%0d valid=%b last=%b data=%0h sum=%0h expected all 0",
                     busy, done, raddr, m_valid, m_last, m_data, checksum);
        end
    endtask

    task automatic test_basic;
        run_scan(0, 8, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        run_scan(0, 8, 1'b1, 1'b0);
        run_scan(5, 12, 1'b1, 1'b0);
    endtask

    task automatic test_wrap;
        run_scan(DEPTH - 2, 4, 1'b0, 1'b0);
    endtask

    task automatic test_count_bounds;
        run_scan(3, 0, 1'b0, 1'b0);
        run_scan(7, DEPTH, 1'b0, 1'b0);
        run_scan(DEPTH - 1, DEPTH, 1'b1, 1'b0);
        run_scan(4, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midscan;
        @(negedge clk);
        start = 1'b1; base_addr = '0; count = (EXP+1)'(16); m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || raddr !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midscan_reset: got busy=%b valid=%b raddr=%0d done=%b expected 0 0 0 0",
                     busy, m_valid, raddr, done);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || m_valid !== 1'b0) begin
                errors++; $display("FAIL no_done_after_abort: got done=%b valid=%b expected 0 0", done, m_valid);
            end
        end
        run_scan(0, 16, 1'b0, 1'b0);
    endtask

    task automatic test_checksum;
        run_scan(8, 3, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        run_scan(10, 6, 1'b0, 1'b0);
        run_scan(2, 9, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = WID'(i * 37 + 5);
        mem[0] = 8'h01; mem[1] = 8'h00; mem[2] = 8'h01; mem[3] = 8'h01;
        mem[4] = 8'h00; mem[5] = 8'h00; mem[6] = 8'h01; mem[7] = 8'h00;
        mem[8] = 8'h12; mem[9] = 8'h34; mem[10] = 8'h56;
        test_reset;
        test_basic;
        test_backpressure;
        test_wrap;
        test_count_bounds;
        test_reset_midscan;
        test_checksum;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
